fetch_controller: RTL



---
 rtl/riscv_pkg.sv | 20 ++
 rtl/fetch_perf_counters.sv | 28 ++
 rtl/fetch_controller.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and constants for the instruction-fetch slice.
//   fetch_state_e - fetch sequencer states (2-bit encoding)
//   XLEN          - address / instruction width
//   INSTR_BYTES   - bytes per instruction word (PC increment)
//   RESET_VECTOR  - default byte address loaded into the PC at reset
package riscv_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_perf_counters.sv
// fetch_perf_counters: wrapping event counters for the fetch stage.
// Only instantiated when FETCH_PERF_CNT_EN is defined.
// Ports:
//   clk, rst_n     - core clock, asynchronous active-low reset
//   fetched_inc    - one instruction handed to decode this cycle
//   killed_inc     - one fetched/presented word discarded this cycle
//   perf_fetched   - count of instructions handed to decode
//   perf_killed    - count of discarded words
module fetch_perf_counters (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetched_inc,
    input  logic        killed_inc,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_killed
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= 32'd0;
            perf_killed  <= 32'd0;
        end else begin
            if (fetched_inc) perf_fetched <= perf_fetched + 32'd1;
            if (killed_inc)  perf_killed  <= perf_killed + 32'd1;
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: instruction-fetch sequencer. Owns the architectural PC,
// issues word requests to instruction memory (req/gnt), presents fetched
// instructions to decode (valid/ready) and applies redirects from execute,
// including killing an in-flight request.
//
// Optional feature macro: FETCH_PERF_CNT_EN adds perf_fetched/perf_killed.
//
// Ports:
//   clk, rst_n                      - core clock, async active-low reset
//   redirect_valid, redirect_target - PC redirect from execute
//   imem_req, imem_addr             - request to instruction memory
//   imem_gnt, imem_rdata            - memory completion and returned word
//   if_valid, if_pc, if_instr       - instruction presented to decode
//   if_ready                        - decode accepts the instruction
//   perf_fetched, perf_killed       - event counters (FETCH_PERF_CNT_EN only)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | dead cycle after reset release, no request
// FETCH | requesting word at pc
// VALID | word held for decode, no request outstanding
// DRAIN | request at pc was killed; wait for its gnt, then go to target
module fetch_controller
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = riscv_pkg::RESET_VECTOR,
    parameter int          XLEN         = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    input  logic            if_ready
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_killed
`endif
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INSTR_BYTES - 1);

    fetch_state_e    state, state_next;
    logic [XLEN-1:0] pc, pc_next;
    logic [XLEN-1:0] instr_q, instr_next;
    logic [XLEN-1:0] pend_target, pend_next;
    logic [XLEN-1:0] target;

    assign target = redirect_target & ALIGN_MASK;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= XLEN'(RESET_VECTOR);
            instr_q     <= '0;
            pend_target <= '0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            instr_q     <= instr_next;
            pend_target <= pend_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        instr_next = instr_q;
        pend_next  = pend_target;
        imem_req   = 1'b0;
        if_valid   = 1'b0;
        case (state)
            IDLE: begin
                state_next = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (redirect_valid) begin
                    if (imem_gnt) begin
                        // word returned for the old pc is dropped; refetch at target
                        pc_next = target;
                    end else begin
                        // pc keeps the killed address so imem_addr stays stable
                        pend_next  = target;
                        state_next = DRAIN;
                    end
                end else if (imem_gnt) begin
                    instr_next = imem_rdata;
                    state_next = VALID;
                end
            end
            VALID: begin
                if_valid = 1'b1;
                if (redirect_valid) begin
                    pc_next    = target;
                    state_next = FETCH;
                end else if (if_ready) begin
                    pc_next    = pc + XLEN'(INSTR_BYTES);
                    state_next = FETCH;
                end
            end
            DRAIN: begin
                imem_req = 1'b1;
                if (imem_gnt) begin
                    pc_next    = redirect_valid ? target : pend_target;
                    state_next = FETCH;
                end else if (redirect_valid) begin
                    pend_next = target;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign imem_addr = pc;
    assign if_pc     = pc;
    assign if_instr  = instr_q;

`ifdef FETCH_PERF_CNT_EN
    logic fetched_inc;
    logic killed_inc;

    assign fetched_inc = (state == VALID) && if_ready && !redirect_valid;
    assign killed_inc  = ((state == FETCH) && redirect_valid && imem_gnt) ||
                         ((state == DRAIN) && imem_gnt) ||
                         ((state == VALID) && redirect_valid);

    fetch_perf_counters u_perf (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetched_inc  (fetched_inc),
        .killed_inc   (killed_inc),
        .perf_fetched (perf_fetched),
        .perf_killed  (perf_killed)
    );
`endif

endmodule
